// File: rtl/l2_dcache_queued.sv
// l2_dcache_queued: L2/memory model sitting behind the L1 D-cache.
//
// Pipelined line reads (up to QUEUE_DEPTH outstanding) complete MISS_PENALTY run cycles after
// acceptance, strictly in order, one response per cycle. Word writes are byte-enabled, independent
// of run_i, and acknowledged one cycle later. The backing store mem[] is never reset, so a bench
// can preload it hierarchically.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   run_i                   0 freezes the read pipeline (no accept, countdown or response)
//   rd_req_i, rd_addr_i     read request and byte address (any alignment within the line)
//   rd_ready_o              read queue has room (registered count only)
//   rd_valid_o              1-cycle response pulse
//   rd_data_o               response line, word i at [i*DATA_W +: DATA_W]
//   rd_tag_o, rd_index_o    tag/index of the responded line
//   wr_req_i, wr_addr_i     word write request and word-aligned byte address
//   wr_data_i, wr_byte_en_i write data and byte enables
//   wr_done_o, wr_err_o     write acknowledge pulse; error if the address is out of range
//   pending_o               outstanding read count
module l2_dcache_queued #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LINE_WORDS   = 4,
  parameter int unsigned MEM_WORDS_LG = 18,
  parameter int unsigned MISS_PENALTY = 2,
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned INDEX_BITS   = 6,
  parameter int unsigned TAG_BITS     = 32 - INDEX_BITS - $clog2(LINE_WORDS) - 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             run_i,
  input  logic                             rd_req_i,
  input  logic [31:0]                      rd_addr_i,
  output logic                             rd_ready_o,
  output logic                             rd_valid_o,
  output logic [DATA_W*LINE_WORDS-1:0]     rd_data_o,
  output logic [TAG_BITS-1:0]              rd_tag_o,
  output logic [INDEX_BITS-1:0]            rd_index_o,
  input  logic                             wr_req_i,
  input  logic [31:0]                      wr_addr_i,
  input  logic [DATA_W-1:0]                wr_data_i,
  input  logic [DATA_W/8-1:0]              wr_byte_en_i,
  output logic                             wr_done_o,
  output logic                             wr_err_o,
  output logic [$clog2(QUEUE_DEPTH):0]     pending_o
);

  localparam int unsigned OffBits  = $clog2(LINE_WORDS) + 2;
  localparam int unsigned PtrW     = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW     = $clog2(MISS_PENALTY + 1);
  localparam int unsigned MemDepth = 2 ** MEM_WORDS_LG;
  localparam int unsigned NBytes   = DATA_W / 8;
  localparam logic [PtrW:0] QFull  = (PtrW + 1)'(QUEUE_DEPTH);

  // Backing store: deliberately no reset.
  logic [DATA_W-1:0] mem [MemDepth];

  // Read queue: line base address plus a countdown of remaining run cycles.
  logic [31:0]   base_q [QUEUE_DEPTH];
  logic [CntW-1:0] cd_q [QUEUE_DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [PtrW:0]   count_q;

  logic                         rd_valid_q;
  logic [DATA_W*LINE_WORDS-1:0] rd_data_q;
  logic [TAG_BITS-1:0]          rd_tag_q;
  logic [INDEX_BITS-1:0]        rd_index_q;
  logic                         wr_done_q, wr_err_q;

  logic                         accept, pop;
  logic [31:0]                  head_base;
  logic                         head_oor;
  logic [DATA_W*LINE_WORDS-1:0] line_d;
  logic [MEM_WORDS_LG-1:0]      widx;
  logic [DATA_W-1:0]            word;

  logic [MEM_WORDS_LG-1:0]      wr_idx;
  logic                         wr_in_range;
  logic                         wr_fire;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr_i[1:0], rd_addr_i[OffBits-1:0], head_base[1:0]};

  assign wr_idx      = wr_addr_i[MEM_WORDS_LG+1:2];
  assign wr_in_range = (wr_addr_i[31:MEM_WORDS_LG+2] == '0);
  assign wr_fire     = wr_req_i & wr_in_range;

  assign rd_ready_o = ~reset & (count_q != QFull);
  assign accept     = run_i & rd_req_i & (count_q != QFull);
  assign head_base  = base_q[head_q];
  // Entries are accepted on distinct edges and count down together, so only the head can hit 1.
  assign pop        = run_i & (count_q != '0) & (cd_q[head_q] == CntW'(1));
  assign head_oor   = (head_base[31:MEM_WORDS_LG+2] != '0);

  // Assemble the head line; a same-edge write is merged in so the response sees it.
  always_comb begin
    line_d = '0;
    widx   = '0;
    word   = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      widx = head_base[MEM_WORDS_LG+1:2] + MEM_WORDS_LG'(w);
      word = mem[widx];
      if (wr_fire && (wr_idx == widx)) begin
        for (int b = 0; b < NBytes; b++) begin
          if (wr_byte_en_i[b]) word[8*b +: 8] = wr_data_i[8*b +: 8];
        end
      end
      if (head_oor) word = DATA_W'(32'hdeadbeef);
      line_d[w*DATA_W +: DATA_W] = word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_tag_q   <= '0;
      rd_index_q <= '0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        base_q[i] <= '0;
        cd_q[i]   <= '0;
      end
    end else begin
      if (run_i) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
          if (cd_q[i] != '0) cd_q[i] <= cd_q[i] - CntW'(1);
        end
      end
      // The tail slot is free (countdown 0), so this load never collides with the decrement.
      if (accept) begin
        base_q[tail_q] <= {rd_addr_i[31:OffBits], OffBits'(0)};
        cd_q[tail_q]   <= CntW'(MISS_PENALTY);
        tail_q         <= tail_q + PtrW'(1);
      end
      rd_valid_q <= pop;
      if (pop) begin
        head_q     <= head_q + PtrW'(1);
        rd_data_q  <= line_d;
        rd_tag_q   <= head_base[31 -: TAG_BITS];
        rd_index_q <= head_base[OffBits +: INDEX_BITS];
      end
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
      wr_done_q <= wr_req_i;
      wr_err_q  <= wr_req_i & ~wr_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < NBytes; b++) begin
        if (wr_byte_en_i[b]) mem[wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_tag_o   = rd_tag_q;
  assign rd_index_o = rd_index_q;
  assign wr_done_o  = wr_done_q;
  assign wr_err_o   = wr_err_q;
  assign pending_o  = count_q;

endmodule
